// File: rtl/systolic_psum_collector.sv
// Drains the bottom row of a systolic array: de-skews column partial sums, accumulates
// them over a configurable number of passes and queues finished row vectors in a small FIFO.
module systolic_psum_collector #(
    parameter int COLS       = 8,
    parameter int PSUM_DW    = 20,
    parameter int ACC_DW     = 24,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clr,
    input  logic [3:0]                cfg_passes,
    input  logic                      in_valid,
    input  logic [COLS*PSUM_DW-1:0]   in_psum,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [COLS*ACC_DW-1:0]    out_data,
    output logic                      almost_full,
    output logic                      err_overflow
);
    localparam int SKEW = COLS - 1;
    localparam int VW   = (SKEW > 0) ? SKEW : 1;
    localparam int PW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW   = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] AF_CNT   = CW'(FIFO_DEPTH - 1);

    logic [VW-1:0]                     vld_r;
    logic                              aligned_valid_s;
    logic [COLS-1:0][PSUM_DW-1:0]      aligned_psum_s;
    logic [COLS-1:0][ACC_DW-1:0]       acc_r;
    logic [COLS-1:0][ACC_DW-1:0]       sum_s;
    logic [3:0]                        pass_cnt_r;
    logic [3:0]                        n_r;
    logic [3:0]                        n_eff_s;
    logic                              first_s;
    logic                              last_s;
    logic                              push_s;
    logic                              push_ok_s;
    logic                              pop_s;
    logic                              full_s;
    logic [PW-1:0]                     wr_ptr_r;
    logic [PW-1:0]                     rd_ptr_r;
    logic [PW-1:0]                     rd_nxt_s;
    logic [CW-1:0]                     cnt_r;
    logic [CW-1:0]                     cnt_nxt_s;
    logic [COLS*ACC_DW-1:0]            mem_r [FIFO_DEPTH];
    logic [COLS*ACC_DW-1:0]            head_nxt_s;
    logic                              out_valid_r;
    logic [COLS*ACC_DW-1:0]            out_data_r;
    logic                              almost_full_r;
    logic                              err_overflow_r;

    // Valid skew chain: column 0 valid delayed COLS-1 cycles marks the aligned vector
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_r <= '0;
        end else if (clr) begin
            vld_r <= '0;
        end else begin
            vld_r[0] <= in_valid;
            for (int i = 1; i < VW; i++) begin
                vld_r[i] <= vld_r[i-1];
            end
        end
    end

    assign aligned_valid_s = (SKEW == 0) ? in_valid : vld_r[VW-1];

    // Column j waits COLS-1-j stages; the last column is tapped straight from the input
    for (genvar j = 0; j < COLS; j++) begin : g_col
        localparam int D = COLS - 1 - j;
        if (D == 0) begin : g_direct
            assign aligned_psum_s[j] = in_psum[j*PSUM_DW +: PSUM_DW];
        end else begin : g_skew
            logic [PSUM_DW-1:0] stg_r [D];
            // Data-only skew pipeline, not touched by clr
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int k = 0; k < D; k++) begin
                        stg_r[k] <= '0;
                    end
                end else begin
                    stg_r[0] <= in_psum[j*PSUM_DW +: PSUM_DW];
                    for (int k = 1; k < D; k++) begin
                        stg_r[k] <= stg_r[k-1];
                    end
                end
            end
            assign aligned_psum_s[j] = stg_r[D-1];
        end
    end

    // Group bookkeeping and per-column sign-extended sums
    always_comb begin
        first_s = (pass_cnt_r == 4'd0);
        if (first_s) begin
            n_eff_s = (cfg_passes == 4'd0) ? 4'd1 : cfg_passes;
        end else begin
            n_eff_s = n_r;
        end
        last_s = (pass_cnt_r == (n_eff_s - 4'd1));
        for (int j = 0; j < COLS; j++) begin
            if (first_s) begin
                sum_s[j] = ACC_DW'(signed'(aligned_psum_s[j]));
            end else begin
                sum_s[j] = acc_r[j] + ACC_DW'(signed'(aligned_psum_s[j]));
            end
        end
    end

    // Accumulator and pass counter; the group length is frozen on the first pass
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass_cnt_r <= 4'd0;
            n_r        <= 4'd1;
            acc_r      <= '0;
        end else if (clr) begin
            pass_cnt_r <= 4'd0;
        end else if (aligned_valid_s) begin
            n_r        <= n_eff_s;
            acc_r      <= sum_s;
            pass_cnt_r <= last_s ? 4'd0 : (pass_cnt_r + 4'd1);
        end
    end

    // FIFO control: a full FIFO still takes a row if the head leaves in the same cycle
    always_comb begin
        push_s    = aligned_valid_s && last_s;
        pop_s     = out_valid_r && out_ready;
        full_s    = (cnt_r == FULL_CNT);
        push_ok_s = push_s && (!full_s || pop_s);
        rd_nxt_s  = pop_s ? (rd_ptr_r + PW'(1)) : rd_ptr_r;
        case ({push_ok_s, pop_s})
            2'b10:   cnt_nxt_s = cnt_r + CW'(1);
            2'b01:   cnt_nxt_s = cnt_r - CW'(1);
            default: cnt_nxt_s = cnt_r;
        endcase
        if (push_ok_s && (rd_nxt_s == wr_ptr_r)) begin
            head_nxt_s = sum_s;
        end else begin
            head_nxt_s = mem_r[rd_nxt_s];
        end
    end

    // FIFO storage, pointers and registered head/valid/overflow outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < FIFO_DEPTH; k++) begin
                mem_r[k] <= '0;
            end
            wr_ptr_r       <= '0;
            rd_ptr_r       <= '0;
            cnt_r          <= '0;
            out_valid_r    <= 1'b0;
            out_data_r     <= '0;
            err_overflow_r <= 1'b0;
        end else if (clr) begin
            wr_ptr_r       <= '0;
            rd_ptr_r       <= '0;
            cnt_r          <= '0;
            out_valid_r    <= 1'b0;
            err_overflow_r <= 1'b0;
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= sum_s;
                wr_ptr_r        <= wr_ptr_r + PW'(1);
            end
            if (push_s && !push_ok_s) begin
                err_overflow_r <= 1'b1;
            end
            rd_ptr_r    <= rd_nxt_s;
            cnt_r       <= cnt_nxt_s;
            out_valid_r <= (cnt_nxt_s != '0);
            out_data_r  <= head_nxt_s;
        end
    end

    // Stall request trails the occupancy by one cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            almost_full_r <= 1'b0;
        end else begin
            almost_full_r <= (cnt_r >= AF_CNT);
        end
    end

    assign out_valid    = out_valid_r;
    assign out_data     = out_data_r;
    assign almost_full  = almost_full_r;
    assign err_overflow = err_overflow_r;

endmodule

// File: tb/tb_systolic_psum_collector.sv
// Bench for systolic_psum_collector: two instances (24-bit and 20-bit accumulators) share
// directed skewed stimulus and are checked every cycle against a row-level queue model.
module tb_systolic_psum_collector;
    localparam int C    = 8;
    localparam int PDW  = 20;
    localparam int ADA  = 24;
    localparam int ADB  = 20;
    localparam int DEP  = 4;
    localparam int MAXC = 256;

    typedef logic [C-1:0][63:0] row_t;

    logic clk = 1'b0;
    logic rst_n, clr, in_valid, out_ready;
    logic [3:0] cfg_passes;
    logic [C*PDW-1:0] in_psum;
    logic ova, ovb, afa, afb, era, erb;
    logic [C*ADA-1:0] oda;
    logic [C*ADB-1:0] odb;

    always #5 clk = ~clk;

    systolic_psum_collector #(.COLS(C), .PSUM_DW(PDW), .ACC_DW(ADA), .FIFO_DEPTH(DEP)) dut_a (
        .clk(clk), .rst_n(rst_n), .clr(clr), .cfg_passes(cfg_passes), .in_valid(in_valid),
        .in_psum(in_psum), .out_valid(ova), .out_ready(out_ready), .out_data(oda),
        .almost_full(afa), .err_overflow(era));

    systolic_psum_collector #(.COLS(C), .PSUM_DW(PDW), .ACC_DW(ADB), .FIFO_DEPTH(DEP)) dut_b (
        .clk(clk), .rst_n(rst_n), .clr(clr), .cfg_passes(cfg_passes), .in_valid(in_valid),
        .in_psum(in_psum), .out_valid(ovb), .out_ready(out_ready), .out_data(odb),
        .almost_full(afb), .err_overflow(erb));

    // stimulus schedule: a row started at cycle t feeds column j at cycle t+j
    bit   vsched [MAXC];
    bit   killed [MAXC];
    row_t rowv   [MAXC];

    // model state
    row_t q[$];
    row_t macc;
    int   mpass = 0, mn = 1;
    bit   merr = 0, maf = 0;

    int cyc = 0, nchk = 0, nerr = 0;
    logic rst_v = 1'b0, clr_v = 1'b0, rdy_v = 1'b1;
    logic [3:0] cfg_v = 4'd1;

    task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
        end
    endtask

    task automatic sched_row(int t, longint base, longint stp);
        vsched[t] = 1'b1;
        for (int j = 0; j < C; j++) rowv[t][j] = base + stp * j;
    endtask

    task automatic cmp_cycle();
        bit v;
        v = (q.size() != 0);
        chk("out_valid_a", ova, v);
        chk("out_valid_b", ovb, v);
        chk("almost_full_a", afa, maf);
        chk("almost_full_b", afb, maf);
        chk("err_overflow_a", era, merr);
        chk("err_overflow_b", erb, merr);
        if (v) begin
            for (int j = 0; j < C; j++) begin
                chk("data_a", oda[j*ADA +: ADA], q[0][j][ADA-1:0]);
                chk("data_b", odb[j*ADB +: ADB], q[0][j][ADB-1:0]);
            end
        end
    endtask

    task automatic drive();
        rst_n      = rst_v;
        clr        = clr_v;
        cfg_passes = cfg_v;
        out_ready  = rdy_v;
        in_valid   = vsched[cyc];
        for (int j = 0; j < C; j++) begin
            if (cyc - j >= 0 && vsched[cyc-j]) in_psum[j*PDW +: PDW] = rowv[cyc-j][j][PDW-1:0];
            else in_psum[j*PDW +: PDW] = PDW'($urandom);
        end
    endtask

    // what the next rising edge must do, from the rules on whole rows
    task automatic model_update();
        int s;
        bit aligned, pop, push, full, af_next;
        af_next = (q.size() >= DEP - 1);
        if (!rst_n || clr) begin
            for (int k = cyc - C + 1; k <= cyc; k++) if (k >= 0) killed[k] = 1'b1;
            maf = rst_n ? af_next : 1'b0;
            q.delete();
            mpass = 0;
            merr = 1'b0;
        end else begin
            s = cyc - (C - 1);
            aligned = (s >= 0) && vsched[s] && !killed[s];
            pop  = (q.size() != 0) && out_ready;
            full = (q.size() == DEP);
            push = 1'b0;
            if (aligned) begin
                if (mpass == 0) begin
                    mn = (cfg_passes == 4'd0) ? 1 : int'(cfg_passes);
                    macc = rowv[s];
                end else begin
                    for (int j = 0; j < C; j++) macc[j] = macc[j] + rowv[s][j];
                end
                mpass++;
                if (mpass == mn) begin
                    mpass = 0;
                    if (!full || pop) push = 1'b1;
                    else merr = 1'b1;
                end
            end
            if (pop) void'(q.pop_front());
            if (push) q.push_back(macc);
            maf = af_next;
        end
    endtask

    task automatic step();
        @(negedge clk);
        cmp_cycle();
        drive();
        model_update();
        cyc++;
    endtask

    task automatic run_to(int k);
        while (cyc < k) step();
    endtask

    initial begin
        rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        cfg_passes = 4'd1; in_psum = '0;
        for (int i = 0; i < MAXC; i++) begin vsched[i] = 1'b0; killed[i] = 1'b0; end

        // reset values
        run_to(3);
        chk("rst_out_valid", ova, 1'b0);
        chk("rst_out_data", oda, 64'd0);
        chk("rst_almost_full", afa, 1'b0);
        chk("rst_err", era, 1'b0);
        rst_v = 1'b1;

        // single pass, column j = j+1, latency COLS
        sched_row(10, 1, 1);
        run_to(18);
        chk("lat_early_valid", ova, 1'b0);
        run_to(19);
        chk("lat_valid", ova, 1'b1);
        chk("lat_col0", oda[0 +: ADA], 24'd1);
        chk("lat_col7", oda[7*ADA +: ADA], 24'd8);
        run_to(20);
        chk("lat_once", ova, 1'b0);

        // three passes 5,-2,100; cfg change mid-group ignored
        cfg_v = 4'd3;
        sched_row(30, 5, 0); sched_row(31, -2, 0); sched_row(32, 100, 0);
        run_to(38);
        cfg_v = 4'd1;
        run_to(40);
        chk("acc3_early", ova, 1'b0);
        run_to(41);
        chk("acc3_valid", ova, 1'b1);
        chk("acc3_col0", oda[0 +: ADA], 24'd103);
        chk("acc3_col7_b", odb[7*ADB +: ADB], 20'd103);

        // two passes 0x7FFFF + 1: wraps at 20 bits, not at 24
        cfg_v = 4'd2;
        sched_row(50, 64'h7FFFF, 0); sched_row(51, 1, 0);
        run_to(60);
        chk("wrap_b", odb[0 +: ADB], 20'h80000);
        chk("wrap_a", oda[0 +: ADA], 24'h080000);

        // fill with consumer stalled, fifth row overflows
        cfg_v = 4'd1; rdy_v = 1'b0;
        for (int k = 0; k < 5; k++) sched_row(70 + k, 10 * (k + 1), 1);
        run_to(81);
        chk("af_not_yet", afa, 1'b0);
        run_to(82);
        chk("af_high", afa, 1'b1);
        run_to(83);
        chk("ovf_err", era, 1'b1);
        chk("ovf_head", oda[0 +: ADA], 24'd10);
        rdy_v = 1'b1;
        run_to(92);
        chk("drained", ova, 1'b0);

        // clr, then full FIFO with a same-cycle pop: no overflow
        clr_v = 1'b1;
        run_to(96);
        clr_v = 1'b0;
        run_to(97);
        chk("clr_err", era, 1'b0);
        rdy_v = 1'b0;
        for (int k = 0; k < 5; k++) sched_row(100 + k, 200 + k, 0);
        run_to(111);
        rdy_v = 1'b1;
        run_to(112);
        rdy_v = 1'b0;
        run_to(113);
        chk("pp_no_err", era, 1'b0);
        chk("pp_head", oda[0 +: ADA], 24'd201);
        run_to(115);
        chk("pp_af", afa, 1'b1);
        rdy_v = 1'b1;
        run_to(125);

        // clr while a row is in flight
        sched_row(130, 7, 0);
        run_to(133);
        clr_v = 1'b1;
        run_to(134);
        clr_v = 1'b0;
        sched_row(145, 9, 0);
        run_to(153);
        chk("clr_flight_none", ova, 1'b0);
        run_to(154);
        chk("clr_next_valid", ova, 1'b1);
        chk("clr_next_col3", oda[3*ADA +: ADA], 24'd9);

        // reset mid-group; new group with cfg 0 acts as one pass
        cfg_v = 4'd2;
        sched_row(170, 3, 0);
        run_to(178);
        rst_v = 1'b0;
        run_to(180);
        chk("rst_mid_valid", ova, 1'b0);
        chk("rst_mid_data", odb, 64'd0);
        rst_v = 1'b1; cfg_v = 4'd0;
        sched_row(185, 11, 0);
        run_to(194);
        chk("post_rst_valid", ova, 1'b1);
        chk("post_rst_col0", oda[0 +: ADA], 24'd11);
        run_to(200);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule

// File: doc/systolic_psum_collector.md
SYSTOLIC_PSUM_COLLECTOR -- requirements
Module: systolic_psum_collector

Interface
REQ-001 Parameter COLS, default 8: number of array columns drained.
REQ-002 Parameter PSUM_DW, default 20: signed partial-sum width per column from the bottom PE row.
REQ-003 Parameter ACC_DW, default 24: signed accumulator and output width per column; ACC_DW SHALL be >= PSUM_DW.
REQ-004 Parameter FIFO_DEPTH, default 4: output FIFO entries, one aligned row vector per entry; power of two.
REQ-005 clk  input  1  clock; all logic rising-edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 clr  input  1  synchronous flush of skew valids, pass counter, FIFO and error flag.
REQ-008 cfg_passes  input  4  number of passes accumulated per output; 0 is treated as 1.
REQ-009 in_valid  input  1  column-0 psum valid; column j is valid exactly j cycles later.
REQ-010 in_psum  input  COLS*PSUM_DW  bottom-row psums; column j occupies bits [j*PSUM_DW +: PSUM_DW].
REQ-011 out_valid  output  1  FIFO non-empty.
REQ-012 out_ready  input  1  consumer accepts out_data when out_valid is high.
REQ-013 out_data  output  COLS*ACC_DW  accumulated row vector from the FIFO head; column j occupies [j*ACC_DW +: ACC_DW].
REQ-014 almost_full  output  1  FIFO occupancy >= FIFO_DEPTH-1; upstream stall request.
REQ-015 err_overflow  output  1  sticky; a completed row was dropped because the FIFO was full.

Function
REQ-016 Column j input SHALL be delayed by COLS-1-j register stages, so all columns align with in_valid delayed COLS-1 cycles (aligned_valid).
REQ-017 Column COLS-1 SHALL use zero skew stages; the aligned vector SHALL be formed from registered and direct column taps, with no column sampled twice.
REQ-018 The psum SHALL be sign-extended PSUM_DW->ACC_DW; accumulation SHALL be two's-complement modulo 2^ACC_DW, with no saturation.
REQ-019 pass_cnt (4 bit) SHALL count aligned_valid events within a group.
REQ-020 The group length N SHALL be latched from cfg_passes (0->1) on the aligned_valid where pass_cnt==0; cfg_passes changes mid-group SHALL have no effect on the current group.
REQ-021 On aligned_valid with pass_cnt==0: acc <= ext(psum).
REQ-022 On aligned_valid with 0<pass_cnt<N-1: acc <= acc + ext(psum).
REQ-023 On aligned_valid with pass_cnt==N-1: push (pass_cnt==0 ? ext(psum) : acc+ext(psum)) into the FIFO and set pass_cnt <= 0; acc is don't-care afterwards.
REQ-024 Latency: for N=1, in_valid in cycle t SHALL produce out_valid in cycle t+COLS when the FIFO was empty.
REQ-025 A push SHALL be accepted when the FIFO is not full, or when it is full and a pop occurs in the same cycle.
REQ-026 Otherwise the completed row SHALL be discarded, err_overflow SHALL be set, and pass_cnt SHALL still return to 0.
REQ-027 Pop occurs when out_valid && out_ready; out_data SHALL be stable while out_valid && !out_ready.
REQ-028 Simultaneous push and pop SHALL leave occupancy unchanged; FIFO pointers wrap modulo FIFO_DEPTH.
REQ-029 almost_full SHALL be a registered function of occupancy, updated the cycle after occupancy changes.
REQ-030 clr SHALL take priority over same-cycle in_valid, push and pop: skew valids, pass_cnt and FIFO are emptied and err_overflow is cleared.
REQ-031 After clr, in-flight skewed data SHALL produce no output.
REQ-032 Skew data registers need not be cleared by clr; only valids are cleared.

Reset
REQ-033 While rst_n is low: out_valid=0, out_data=0, almost_full=0, err_overflow=0, pass_cnt=0, all skew valids=0, FIFO pointers and occupancy=0.
REQ-034 Reset assertion mid-group or with a full FIFO SHALL discard all state; the first aligned_valid after release starts a new group.

Verification
REQ-035 COLS=8, N=1, out_ready=1: in_valid at t=10 with column j = j+1 -> out_valid at cycle 18 only, out_data columns = 1..8.
REQ-036 N=3: three vectors with all columns = 5, -2, 100 -> one output with all columns 103; out_valid only after the third aligned_valid.
REQ-037 ACC_DW=PSUM_DW=20, N=2: columns 0x7FFFF + 1 -> output 0x80000 (wrap, no saturation).
REQ-038 out_ready=0, FIFO_DEPTH=4, N=1: 5 rows -> almost_full high after the 3rd push; 4 entries held; err_overflow set on the 5th; popping returns rows 1..4 in order.
REQ-039 Full FIFO with out_ready=1 in the same cycle as the 5th push -> no overflow; occupancy stays 4.
REQ-040 clr asserted 3 cycles after in_valid, N=1 -> no out_valid; err_overflow=0; the next in_valid yields normal output at +COLS cycles.
